// File: rtl/ifetch_queue_if.sv
// Fetch-queue bundle: instruction-memory read port, decode-side head port
// and the branch redirect.
interface ifetch_queue_if;
  logic        mem_read;
  logic [15:0] mem_address;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  modport master (
    output mem_read, mem_address, inst_valid, inst, inst_pc,
    input  mem_resp, mem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_read, mem_address, inst_valid, inst, inst_pc,
    output mem_resp, mem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches sequential halfwords into a small FIFO
// and restarts from a new PC on redirect.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  ifetch_queue_if.master         bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  typedef enum logic {FETCH, SQUASH} state_t;

  state_t           state_q, state_d;
  logic [15:0]      fpc;
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   cnt;
  logic             mem_read, push, pop;

  logic [15:0] pc_mem   [DEPTH];
  logic [15:0] word_mem [DEPTH];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    mem_read = 1'b0;
    // rst gates the request directly: the registers already read FETCH/0 while held in reset.
    if (!rst && state_q == FETCH && cnt != FULL_CNT)
      mem_read = 1'b1;
    if (bus.redirect)
      state_d = SQUASH;
    else if (state_q == SQUASH)
      state_d = FETCH;
  end

  assign push = mem_read && bus.mem_resp && !bus.redirect;
  assign pop  = (cnt != '0) && bus.inst_ready && !bus.redirect;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc  <= RESET_PC;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (bus.redirect) begin
      fpc  <= bus.redirect_pc & 16'hFFFE;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        fpc  <= fpc + 16'd2;
        tail <= tail + 1'b1;
      end
      if (pop)
        head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: entry storage has no reset; cnt alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= fpc;
      word_mem[tail] <= bus.mem_rdata;
    end
  end

  assign bus.mem_read    = mem_read;
  assign bus.mem_address = fpc;
  assign bus.inst_valid  = (cnt != '0);
  assign bus.inst        = word_mem[head];
  assign bus.inst_pc     = pc_mem[head];
  assign count           = cnt;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: streaming, full/backpressure, redirect,
// PC wrap, simultaneous push/pop and asynchronous reset.
module tb_ifetch_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count;
  int         n_checks = 0;
  int         n_pass   = 0;

  ifetch_queue_if bus();

  ifetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  // Memory model: the word at an address is the address XOR a fixed pattern.
  assign bus.mem_rdata = bus.mem_address ^ 16'h5A5A;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Inputs change just after the falling edge; outputs are read there too.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_in(input logic resp, input logic ready, input logic redir,
                        input logic [15:0] rpc);
    bus.mem_resp    = resp;
    bus.inst_ready  = ready;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b1;
    tick();
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(bus.inst_valid), 0);
    check("rst_mem_read", 32'(bus.mem_read), 0);
    check("rst_addr", 32'(bus.mem_address), 32'h0000);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_mem_read", 32'(bus.mem_read), 1);
    check("post_rst_addr", 32'(bus.mem_address), 32'h0000);
  endtask

  initial begin
    logic [15:0] wrap_pcs [4];
    wrap_pcs = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 16'h0000);

    // Streaming: response every cycle, decode always ready.
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("stream_addr", 32'(bus.mem_address), 32'(2 * i));
      check("stream_valid", 32'(bus.inst_valid), 1);
      check("stream_pc", 32'(bus.inst_pc), 32'(2 * (i - 1)));
      check("stream_word", 32'(bus.inst), 32'((2 * (i - 1)) ^ 16'h5A5A));
      check("stream_count", 32'(count), 1);
    end

    // Fill with decode stalled.
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (4) tick();
    check("full_count", 32'(count), 4);
    check("full_mem_read", 32'(bus.mem_read), 0);
    check("full_addr", 32'(bus.mem_address), 32'h0008);
    check("full_head_pc", 32'(bus.inst_pc), 32'h0000);
    tick();
    check("full_resp_ignored", 32'(count), 4);
    check("full_addr_hold", 32'(bus.mem_address), 32'h0008);
    set_in(1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    check("pop_full_count", 32'(count), 3);
    check("pop_full_mem_read", 32'(bus.mem_read), 1);
    check("pop_full_head", 32'(bus.inst_pc), 32'h0002);
    set_in(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    check("hold3_count", 32'(count), 3);

    // Redirect with count=3; same-cycle response and pop are discarded.
    set_in(1'b1, 1'b1, 1'b1, 16'h0101);
    tick();
    check("redir_count", 32'(count), 0);
    check("redir_valid", 32'(bus.inst_valid), 0);
    check("redir_mem_read", 32'(bus.mem_read), 0);
    check("redir_addr", 32'(bus.mem_address), 32'h0100);
    set_in(1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    check("squash_drop", 32'(count), 0);
    check("squash_exit_read", 32'(bus.mem_read), 1);
    check("squash_exit_addr", 32'(bus.mem_address), 32'h0100);
    tick();
    check("redir_first_pc", 32'(bus.inst_pc), 32'h0100);
    check("redir_first_word", 32'(bus.inst), 32'h0100 ^ 32'h5A5A);

    // Back-to-back redirects, newest wins, then wrap through 0xFFFE.
    set_in(1'b1, 1'b0, 1'b1, 16'h1234);
    tick();
    check("redir2a_addr", 32'(bus.mem_address), 32'h1234);
    set_in(1'b1, 1'b0, 1'b1, 16'hFFFD);
    tick();
    check("redir2b_addr", 32'(bus.mem_address), 32'hFFFC);
    check("redir2b_mem_read", 32'(bus.mem_read), 0);
    set_in(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    check("redir2_exit_read", 32'(bus.mem_read), 1);
    check("redir2_exit_count", 32'(count), 0);
    repeat (4) tick();
    check("wrap_count", 32'(count), 4);
    check("wrap_addr", 32'(bus.mem_address), 32'h0004);
    set_in(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      check("wrap_pc", 32'(bus.inst_pc), 32'(wrap_pcs[i]));
      check("wrap_word", 32'(bus.inst), 32'(wrap_pcs[i] ^ 16'h5A5A));
      tick();
    end
    check("wrap_drained", 32'(count), 0);

    // Simultaneous push and pop at count=2.
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (2) tick();
    check("pp_pre_count", 32'(count), 2);
    set_in(1'b1, 1'b1, 1'b0, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("pp_count", 32'(count), 2);
      check("pp_head_pc", 32'(bus.inst_pc), 32'(2 * i));
    end
    set_in(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    check("pp_hold_count", 32'(count), 2);

    // Asynchronous reset between edges with count=2.
    @(posedge clk);
    #2;
    set_in(1'b1, 1'b1, 1'b0, 16'h0000);
    rst = 1'b1;
    #1;
    check("async_count", 32'(count), 0);
    check("async_valid", 32'(bus.inst_valid), 0);
    check("async_mem_read", 32'(bus.mem_read), 0);
    check("async_addr", 32'(bus.mem_address), 32'h0000);
    tick();
    tick();
    check("async_held", 32'(count), 0);
    rst = 1'b0;
    #1;
    check("async_release_read", 32'(bus.mem_read), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
